// File: rtl/uart_unit.sv
// ---------------------------------------------------------------------------
// uart_unit
// Serial I/O stage for the control unit. Executes the snd / rcv / baud
// commands presented on uartc, owns an 8N1 transmitter and receiver, each
// backed by a small circular FIFO, and a run-time programmable baud divisor.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   uartc[2:0]   command: 010 rcv, 011 snd, 100 baud, anything else idle
//   wr_data[31:0] operand: [7:0] byte for snd, [15:0] divisor for baud
//   rx           asynchronous serial input
//   tx           serial output, idles high
//   rdy          high while the current command is rcv
//   state        high while the RX FIFO is empty (rcv must wait)
//   rx_data      RX FIFO head, zero-extended; 0 while state is high
//   tx_busy      transmitter active or TX FIFO non-empty
//   tx_overflow  sticky: snd dropped on a full TX FIFO
//   rx_overrun   sticky: received byte dropped on a full RX FIFO
//   frame_err    sticky: stop bit sampled low
// ---------------------------------------------------------------------------
module uart_unit #(
    parameter int unsigned DEFAULT_DIV = 434,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  uartc,
    input  logic [31:0] wr_data,
    input  logic        rx,
    output logic        tx,
    output logic        rdy,
    output logic        state,
    output logic [31:0] rx_data,
    output logic        tx_busy,
    output logic        tx_overflow,
    output logic        rx_overrun,
    output logic        frame_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0]    CMD_RCV  = 3'b010;
    localparam logic [2:0]    CMD_SND  = 3'b011;
    localparam logic [2:0]    CMD_BAUD = 3'b100;
    localparam logic [15:0]   DIV_RST  = 16'(DEFAULT_DIV);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_st_e;

    // command decode
    logic rcv_s, snd_s, baud_s;
    assign rcv_s  = (uartc == CMD_RCV);
    assign snd_s  = (uartc == CMD_SND);
    assign baud_s = (uartc == CMD_BAUD);
    assign rdy    = rcv_s;

    // upper operand bits carry no meaning for this unit
    logic unused_wr_s;
    assign unused_wr_s = ^wr_data[31:16];

    // ---------------- state ----------------
    logic [15:0]   div_q, div_d;
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    uart_st_e      tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [15:0]   tx_tmr_q, tx_tmr_d, rx_tmr_q, rx_tmr_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic          tx_q, tx_d;
    logic          tx_busy_q, tx_busy_d;
    logic          state_q, state_d;
    logic          tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, ferr_q, ferr_d;
    logic          rx_s1_q, rx_s2_q, rx_s3_q;

    logic tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
    logic rx_full_s, rx_push_s, rx_pop_s, rx_done_s, rx_ferr_s, rx_fall_s;

    assign tx_full_s  = (tx_cnt_q == CNT_FULL);
    assign tx_empty_s = (tx_cnt_q == {CW{1'b0}});
    assign tx_push_s  = snd_s && (!tx_full_s || tx_pop_s);

    assign rx_full_s  = (rx_cnt_q == CNT_FULL);
    // state_q low guarantees a valid head, so the pop needs no extra guard
    assign rx_pop_s   = rcv_s && !state_q;
    assign rx_push_s  = rx_done_s && (!rx_full_s || rx_pop_s);
    // s3 holds the previous synchronized value for edge detection
    assign rx_fall_s  = rx_s3_q && !rx_s2_q;

    // Divisor and sticky flag next-state; a baud command clears flags, new events still set them
    always_comb begin
        div_d    = div_q;
        tx_ovf_d = tx_ovf_q;
        rx_ovr_d = rx_ovr_q;
        ferr_d   = ferr_q;
        if (baud_s) begin
            div_d    = (wr_data[15:0] < 16'd2) ? 16'd2 : wr_data[15:0];
            tx_ovf_d = 1'b0;
            rx_ovr_d = 1'b0;
            ferr_d   = 1'b0;
        end else begin
            div_d = div_q;
        end
        if (snd_s && tx_full_s && !tx_pop_s) begin
            tx_ovf_d = 1'b1;
        end else begin
            tx_ovf_d = tx_ovf_d;
        end
        if (rx_done_s && rx_full_s && !rx_pop_s) begin
            rx_ovr_d = 1'b1;
        end else begin
            rx_ovr_d = rx_ovr_d;
        end
        if (rx_ferr_s) begin
            ferr_d = 1'b1;
        end else begin
            ferr_d = ferr_d;
        end
    end

    // FIFO occupancy next-state for both directions
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_push_s && !tx_pop_s) begin
            tx_cnt_d = tx_cnt_q + CW'(1);
        end else if (!tx_push_s && tx_pop_s) begin
            tx_cnt_d = tx_cnt_q - CW'(1);
        end else begin
            tx_cnt_d = tx_cnt_q;
        end
        if (rx_push_s && !rx_pop_s) begin
            rx_cnt_d = rx_cnt_q + CW'(1);
        end else if (!rx_push_s && rx_pop_s) begin
            rx_cnt_d = rx_cnt_q - CW'(1);
        end else begin
            rx_cnt_d = rx_cnt_q;
        end
        // a fresh push into an empty FIFO is reported one cycle late; a pop to empty is immediate
        state_d   = (rx_cnt_d == {CW{1'b0}}) || (rx_cnt_q == {CW{1'b0}});
        tx_busy_d = (tx_st_d != ST_IDLE) || (tx_cnt_d != {CW{1'b0}});
    end

    // TX FSM next-state: timer counts div-1 down to 0 per bit, reloaded with the current divisor
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_tmr_d = tx_tmr_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_d     = tx_q;
        tx_pop_s = 1'b0;
        case (tx_st_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!tx_empty_s) begin
                    tx_pop_s = 1'b1;
                    tx_sh_d  = tx_mem_q[tx_rptr_q];
                    tx_d     = 1'b0;
                    tx_tmr_d = div_q - 16'd1;
                    tx_st_d  = ST_START;
                end else begin
                    tx_st_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_tmr_q == 16'd0) begin
                    tx_d     = tx_sh_q[0];
                    tx_tmr_d = div_q - 16'd1;
                    tx_bit_d = 3'd0;
                    tx_st_d  = ST_DATA;
                end else begin
                    tx_tmr_d = tx_tmr_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_tmr_q == 16'd0) begin
                    tx_tmr_d = div_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        tx_st_d = ST_STOP;
                    end else begin
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_d     = tx_sh_q[1];
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_tmr_d = tx_tmr_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_tmr_q == 16'd0) begin
                    if (!tx_empty_s) begin
                        // back-to-back frame: no idle gap after the stop bit
                        tx_pop_s = 1'b1;
                        tx_sh_d  = tx_mem_q[tx_rptr_q];
                        tx_d     = 1'b0;
                        tx_tmr_d = div_q - 16'd1;
                        tx_st_d  = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        tx_st_d = ST_IDLE;
                    end
                end else begin
                    tx_tmr_d = tx_tmr_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                tx_st_d = ST_IDLE;
            end
        endcase
    end

    // RX FSM next-state: half-bit wait to the start-bit centre, then one sample per bit
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_tmr_d  = rx_tmr_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_done_s = 1'b0;
        rx_ferr_s = 1'b0;
        case (rx_st_q)
            ST_IDLE: begin
                if (rx_fall_s) begin
                    rx_tmr_d = (div_q >> 1) - 16'd1;
                    rx_st_d  = ST_START;
                end else begin
                    rx_st_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_tmr_q == 16'd0) begin
                    if (rx_s2_q) begin
                        rx_st_d = ST_IDLE;  // line back high: false start
                    end else begin
                        rx_tmr_d = div_q - 16'd1;
                        rx_bit_d = 3'd0;
                        rx_st_d  = ST_DATA;
                    end
                end else begin
                    rx_tmr_d = rx_tmr_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_tmr_q == 16'd0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_tmr_d = div_q - 16'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_tmr_d = rx_tmr_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_tmr_q == 16'd0) begin
                    rx_st_d = ST_IDLE;
                    if (rx_s2_q) begin
                        rx_done_s = 1'b1;
                    end else begin
                        rx_ferr_s = 1'b1;
                    end
                end else begin
                    rx_tmr_d = rx_tmr_q - 16'd1;
                end
            end
            default: begin
                rx_st_d = ST_IDLE;
            end
        endcase
    end

    // All registered state, async active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= DIV_RST;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= 8'h00;
                rx_mem_q[i] <= 8'h00;
            end
            tx_st_q   <= ST_IDLE;
            rx_st_q   <= ST_IDLE;
            tx_tmr_q  <= 16'd0;
            rx_tmr_q  <= 16'd0;
            tx_bit_q  <= 3'd0;
            rx_bit_q  <= 3'd0;
            tx_sh_q   <= 8'h00;
            rx_sh_q   <= 8'h00;
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            state_q   <= 1'b1;
            tx_ovf_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            ferr_q    <= 1'b0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
        end else begin
            div_q <= div_d;
            if (tx_push_s) begin
                tx_mem_q[tx_wptr_q] <= wr_data[7:0];
                tx_wptr_q           <= tx_wptr_q + AW'(1);
            end
            if (tx_pop_s) begin
                tx_rptr_q <= tx_rptr_q + AW'(1);
            end
            if (rx_push_s) begin
                rx_mem_q[rx_wptr_q] <= rx_sh_q;
                rx_wptr_q           <= rx_wptr_q + AW'(1);
            end
            if (rx_pop_s) begin
                rx_rptr_q <= rx_rptr_q + AW'(1);
            end
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_st_q   <= tx_st_d;
            rx_st_q   <= rx_st_d;
            tx_tmr_q  <= tx_tmr_d;
            rx_tmr_q  <= rx_tmr_d;
            tx_bit_q  <= tx_bit_d;
            rx_bit_q  <= rx_bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            tx_q      <= tx_d;
            tx_busy_q <= tx_busy_d;
            state_q   <= state_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovr_q  <= rx_ovr_d;
            ferr_q    <= ferr_d;
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
        end
    end

    assign tx          = tx_q;
    assign tx_busy     = tx_busy_q;
    assign state       = state_q;
    assign rx_data     = state_q ? 32'd0 : {24'd0, rx_mem_q[rx_rptr_q]};
    assign tx_overflow = tx_ovf_q;
    assign rx_overrun  = rx_ovr_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_uart_unit.sv
// ---------------------------------------------------------------------------
// tb_uart_unit
// Scoreboard bench for uart_unit. Stimulus pushes expected TX bytes and
// expected RX bytes into queues; independent monitors decode the tx line
// and watch completed rcv cycles, popping and comparing.
// ---------------------------------------------------------------------------
module tb_uart_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic [2:0]  uartc;
    logic [31:0] wr_data;
    logic        rx;
    logic        tx;
    logic        rdy;
    logic        state;
    logic [31:0] rx_data;
    logic        tx_busy;
    logic        tx_overflow;
    logic        rx_overrun;
    logic        frame_err;

    uart_unit #(.DEFAULT_DIV(434), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset_n), .uartc(uartc), .wr_data(wr_data), .rx(rx),
        .tx(tx), .rdy(rdy), .state(state), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_overflow(tx_overflow), .rx_overrun(rx_overrun), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_div = 434;
    bit tx_mon_en = 1'b1;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // TX monitor: decode frames at mid-bit using the divisor the bench programmed
    logic       mon_prev;
    logic [7:0] mon_b;
    logic       mon_ok;
    int         mon_d;
    initial begin
        mon_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n && mon_prev && !tx) begin
                mon_d  = cur_div;
                mon_ok = 1'b1;
                repeat (mon_d / 2) @(negedge clk);
                if (tx !== 1'b0) mon_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_d) @(negedge clk);
                    mon_b[i] = tx;
                end
                repeat (mon_d) @(negedge clk);
                if (tx !== 1'b1) mon_ok = 1'b0;
                if (tx_mon_en) begin
                    if (tx_exp.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL tx_unexpected_frame: got 0x%0h, expected none", mon_b);
                    end else begin
                        chk("tx_frame", {23'd0, mon_ok, mon_b}, {23'd0, 1'b1, tx_exp.pop_front()});
                    end
                end
            end
            mon_prev = tx;
        end
    end

    // RX monitor: every cycle that completes a rcv must present the oldest expected byte
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && uartc == 3'b010 && state == 1'b0) begin
                if (rx_exp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rx_unexpected_byte: got 0x%0h, expected none", rx_data);
                end else begin
                    chk("rx_byte", rx_data, {24'd0, rx_exp.pop_front()});
                end
            end
        end
    end

    // baud command; the bench tracks the clamped divisor itself
    task automatic do_baud(input logic [15:0] v);
        uartc   = 3'b100;
        wr_data = {16'd0, v};
        @(negedge clk);
        uartc   = 3'b000;
        cur_div = (v < 16'd2) ? 2 : int'(v);
    endtask

    // drive one 8N1 frame on rx; a good frame is queued in the model if there is room
    task automatic send_rx(input logic [7:0] b, input logic stop);
        int d;
        d = cur_div;
        if (stop && rx_exp.size() < DEPTH) rx_exp.push_back(b);
        rx = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (d) @(negedge clk);
        end
        rx = stop;
        repeat (d) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tx_idle(input int limit);
        int t;
        t = 0;
        while (tx_busy && t < limit) begin
            @(negedge clk);
            t++;
        end
        #1;
        chk("tx_drain_in_time", {31'd0, tx_busy}, 32'd0);
    endtask

    int          errs;
    int          n_burst;
    int          acc;
    int          len;
    int          t;
    logic [7:0]  b;
    logic [7:0]  a5;
    logic        e;

    initial begin
        reset_n = 1'b0;
        uartc   = 3'b000;
        wr_data = 32'd0;
        rx      = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_state", {31'd0, state}, 32'd1);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_flags", {28'd0, tx_busy, tx_overflow, rx_overrun, frame_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single frame, exact waveform at div 16
        do_baud(16'd16);
        a5 = 8'hA5;
        uartc   = 3'b011;
        wr_data = {$urandom() & 32'hFFFF_FF00} | 32'h0000_00A5;
        tx_exp.push_back(a5);
        @(negedge clk);
        uartc = 3'b000;
        #1;
        chk("busy_after_push", {31'd0, tx_busy}, 32'd1);
        chk("tx_high_before_pop", {31'd0, tx}, 32'd1);
        errs = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            #1;
            if (i < 16)       e = 1'b0;
            else if (i < 144) e = a5[(i - 16) / 16];
            else              e = 1'b1;
            if (tx !== e) errs++;
        end
        chk("tx_wave_errors", errs, 32'd0);
        chk("busy_in_stop", {31'd0, tx_busy}, 32'd1);
        @(negedge clk);
        #1;
        chk("busy_after_stop", {31'd0, tx_busy}, 32'd0);

        // snd bursts into an idle transmitter: one pops at once, DEPTH more can queue
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_burst = (k == 0) ? 5 : (k == 1) ? 6 : int'($urandom_range(1, 8));
            acc = (n_burst < DEPTH + 1) ? n_burst : DEPTH + 1;
            for (int j = 0; j < n_burst; j++) begin
                b = (k == 0) ? 8'(j + 1) : 8'($urandom());
                uartc   = 3'b011;
                wr_data = {24'($urandom()), b};
                if (j < acc) tx_exp.push_back(b);
                @(negedge clk);
            end
            uartc = 3'b000;
            wait_tx_idle(7 * 160 + 40);
            chk("tx_overflow", {31'd0, tx_overflow}, {31'd0, (n_burst > DEPTH + 1)});
            do_baud(16'd16);
            #1;
            chk("tx_overflow_cleared", {31'd0, tx_overflow}, 32'd0);
        end

        // rcv on an empty FIFO stalls, then completes when the frame lands
        @(negedge clk);
        uartc = 3'b010;
        #1;
        chk("rcv_rdy", {31'd0, rdy}, 32'd1);
        chk("rcv_wait_state", {31'd0, state}, 32'd1);
        send_rx(8'h3C, 1'b1);
        uartc = 3'b000;
        #1;
        chk("state_after_pop", {31'd0, state}, 32'd1);
        chk("rx_data_empty", rx_data, 32'd0);
        chk("rx_queue_drained", rx_exp.size(), 32'd0);

        // five frames with no rcv: four queue, the fifth overruns
        for (int k = 0; k < 5; k++) send_rx(8'($urandom()), 1'b1);
        #1;
        chk("rx_overrun", {31'd0, rx_overrun}, 32'd1);
        chk("state_nonempty", {31'd0, state}, 32'd0);
        uartc = 3'b010;
        repeat (4) @(negedge clk);
        uartc = 3'b000;
        #1;
        chk("state_after_4_rcv", {31'd0, state}, 32'd1);
        chk("rx_queue_drained2", rx_exp.size(), 32'd0);
        do_baud(16'd16);
        #1;
        chk("rx_overrun_cleared", {31'd0, rx_overrun}, 32'd0);

        // short glitch is a false start; a low stop bit is a framing error
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("glitch_no_err", {31'd0, frame_err}, 32'd0);
        chk("glitch_no_push", {31'd0, state}, 32'd1);
        send_rx(8'($urandom()), 1'b0);
        repeat (20) @(negedge clk);
        #1;
        chk("frame_err_set", {31'd0, frame_err}, 32'd1);
        chk("frame_err_no_push", {31'd0, state}, 32'd1);
        do_baud(16'd1);
        #1;
        chk("frame_err_cleared", {31'd0, frame_err}, 32'd0);
        do_baud(16'd16);

        // reset in the middle of a TX frame and a partial RX frame
        tx_mon_en = 1'b0;
        uartc   = 3'b011;
        wr_data = 32'h0000_00F0;
        @(negedge clk);
        uartc = 3'b000;
        repeat (30) @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("tx_async_reset", {31'd0, tx}, 32'd1);
        chk("busy_async_reset", {31'd0, tx_busy}, 32'd0);
        rx = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        chk("rx_partial_dropped", {31'd0, state}, 32'd1);
        chk("tx_idle_after_reset", {31'd0, tx}, 32'd1);

        // default divisor restored: start bit lasts 434 cycles
        cur_div   = 434;
        tx_mon_en = 1'b1;
        @(negedge clk);
        uartc   = 3'b011;
        wr_data = 32'h0000_0055;
        tx_exp.push_back(8'h55);
        @(negedge clk);
        uartc = 3'b000;
        t = 0;
        while (tx === 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        len = 0;
        while (tx === 1'b0 && len < 1000) begin
            len++;
            @(negedge clk);
        end
        chk("default_div_start_len", len, 32'd434);
        wait_tx_idle(5000);
        repeat (5) @(negedge clk);
        chk("tx_queue_drained", tx_exp.size(), 32'd0);
        chk("rx_queue_final", rx_exp.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_unit.md
# uart_unit

Serial I/O stage driven by the control unit's `uartc[2:0]` command bus. It executes the `snd`, `rcv` and `baud` instructions. It returns `rdy`/`state` to the control unit so `rcv` stalls the PC until a byte is available. It owns an 8N1 transmitter and receiver, each with a small FIFO, and a run-time programmable baud divisor.

## Interface
- `DEFAULT_DIV`, 434: baud divisor after reset, in clk cycles per bit (50 MHz / 115200).
- `FIFO_DEPTH`, 4: entries in each of the TX and RX FIFOs (power of two, ≥2).
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `uartc`  in  3  command: 010 rcv, 011 snd, 100 baud, any other value is idle.
- `wr_data`  in  32  register operand: `[7:0]` is the byte for snd, `[15:0]` is the divisor for baud.
- `rx`  in  1  serial input, asynchronous.
- `tx`  out  1  serial output, idles high.
- `rdy`  out  1  combinational: `uartc == 3'b010`.
- `state`  out  1  registered: 1 while the RX FIFO is empty (rcv must wait).
- `rx_data`  out  32  RX FIFO head, zero-extended; 0 when empty.
- `tx_busy`  out  1  transmitter shifting or TX FIFO non-empty.
- `tx_overflow`  out  1  sticky: snd dropped because the TX FIFO was full.
- `rx_overrun`  out  1  sticky: received byte dropped because the RX FIFO was full.
- `frame_err`  out  1  sticky: stop bit sampled low.

## Operation
- Commands are level-sampled every clk. Each cycle with a valid code counts as one command; consecutive `snd` cycles push consecutive bytes.
- snd (011): push `wr_data[7:0]` into the TX FIFO.
  - If the FIFO is full and no pop happens this cycle, drop the byte and set `tx_overflow`.
  - Push into a full FIFO in the same cycle as a transmitter pop is accepted.
- baud (100): load the divisor from `wr_data[15:0]`, clamped to a minimum of 2.
  - Clears all three sticky flags.
  - Counters mid-bit finish the current bit with the old count; the new divisor applies from the next bit reload.
- rcv (010): with `state`=0, pop the RX FIFO at the clock edge. `rx_data` is valid for the register write in that same cycle.
  - With `state`=1, nothing happens; the control unit holds `hlt`=1 and repeats the command every cycle.
- TX FSM, states IDLE→START→DATA→STOP→IDLE:
  - IDLE: when the FIFO is non-empty, pop one byte into the shift register.
  - START: drive `tx` low for one bit time.
  - DATA: send 8 bits, LSB first.
  - STOP: drive `tx` high for 1 bit time.
  - From STOP, return to IDLE, or pop the next byte and go directly to START with no idle gap.
  - Bit time is `div` cycles.
- RX path: `rx` passes through a 2-flop synchronizer. RX FSM, states IDLE→START→DATA→STOP:
  - IDLE: on a synchronized falling edge, wait `div/2` cycles (integer floor).
  - START: if the line is high at that point, it is a false start; return to IDLE.
  - DATA: sample every `div` cycles, 8 bits, LSB first.
  - STOP: sample after another `div` cycles. If 1, push the byte (if full and no pop this cycle, drop it and set `rx_overrun`). If 0, drop the byte and set `frame_err`. Either way, return to IDLE.
- FIFOs are circular with wrapping pointers and a count of FIFO_DEPTH+1 range, so full and empty are never ambiguous.
  - The RX FIFO allows a simultaneous push and pop when full.
  - Pushing into an empty RX FIFO makes `state` 0 on the next cycle.

## Timing
- Reset values:
  - Outputs: `tx`=1, `state`=1, `rx_data`=0, `tx_busy`=0, all sticky flags 0.
  - Internal: divisor = DEFAULT_DIV, FIFOs empty, both FSMs IDLE, synchronizer flops 1.
  - Reset asserted mid-frame aborts it immediately: `tx` returns high, and any partial RX byte is discarded.
- snd into an idle transmitter:
  - Edge 1: push.
  - Edge 2: pop; `tx` goes low, `tx_busy` high from edge 1.
  - Frame length: exactly 10×div cycles.
- RX: the byte reaches the FIFO at the edge after the stop-bit sample. `state` falls one cycle later. Stop-bit sample point: falling edge + 2 sync + div/2 + 9×div cycles.
- rcv that finds data: zero stall cycles. rcv that waits: stalls until `state`=0, then completes in that cycle.
- `rdy` has zero latency. No combinational path exists from `rx`/`wr_data` to `rdy`/`state`.

## Test plan
- Reset, then baud with `wr_data`=16, then snd 0xA5 for one cycle. `tx` must be: low for 16 cycles; then bits 1,0,1,0,0,1,0,1 for 16 cycles each; then high for 16 cycles. `tx_busy` drops after the stop bit.
- div=16. Issue 5 consecutive snd cycles (0x01–0x05) while idle. All 5 bytes go out back-to-back (the first pops immediately, leaving 4 queued), `tx_overflow`=0. A 6th snd before the first pop sets `tx_overflow`=1.
- rcv with the RX FIFO empty: `rdy`=1, `state`=1 held. Drive frame 0x3C on `rx` at div=16. `state`→0 and `rx_data`=0x0000003C in the same cycle. Pop at the next edge, then `state`=1.
- Send 5 frames on `rx` with no rcv. The first 4 are queued; the 5th sets `rx_overrun`. Then 4 rcv cycles return the bytes in order.
- Frame with the stop bit low, and a 3-cycle low glitch. Required: `frame_err`=1 and nothing pushed; the glitch is a false start with no push and no error. A baud command clears `frame_err`.
- Assert reset mid-TX-frame: `tx`=1 asynchronously, FIFOs empty. After release, divisor is 434.
